// File: rtl/sram_controller_if.sv
// sram_controller_if: host request/response handshake bundle for sram_controller.
interface sram_controller_if #(
    parameter int ADR = 8,
    parameter int DAT = 8
);
    logic           req_valid;
    logic           req_ready;
    logic           req_write;
    logic [ADR-1:0] req_addr;
    logic [DAT-1:0] req_data;
    logic           rsp_valid;
    logic           rsp_err;
    logic [DAT-1:0] rsp_data;
    modport master (
        output req_valid, req_write, req_addr, req_data,
        input  req_ready, rsp_valid, rsp_err, rsp_data
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_data,
        output req_ready, rsp_valid, rsp_err, rsp_data
    );
endinterface

// File: rtl/sram_controller.sv
// sram_controller: single-request host initiator for a synchronous single-port SRAM with registered strobes.
module sram_controller #(
    parameter int ADR  = 8,
    parameter int DAT  = 8,
    parameter int DPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_controller_if.slave     bus,
    output logic                 chip_select_o,
    output logic                 write_enable_o,
    output logic                 read_enable_o,
    output logic [ADR-1:0]       addr_o,
    output logic [DAT-1:0]       data_in_o,
    input  logic [DAT-1:0]       data_out_i
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;
    // One extra bit so DPTH == 2**ADR still compares correctly.
    localparam logic [ADR:0] DEPTH = (ADR+1)'(DPTH);
    state_t         state_q, state_d;
    logic           cs_q, cs_d, we_q, we_d, re_q, re_d;
    logic           rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [ADR-1:0] addr_q, addr_d;
    logic [DAT-1:0] din_q, din_d, rsp_data_q, rsp_data_d;
    logic           accept, in_range;
    assign accept   = bus.req_valid && state_q == IDLE;
    assign in_range = {1'b0, bus.req_addr} < DEPTH;
    always_comb begin
        state_d     = state_q;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        re_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: if (accept) begin
                if (!in_range) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                end else begin
                    cs_d    = 1'b1;
                    we_d    = bus.req_write;
                    re_d    = !bus.req_write;
                    addr_d  = bus.req_addr;
                    din_d   = bus.req_write ? bus.req_data : din_q;
                    state_d = bus.req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                state_d     = IDLE;
            end
            READ: state_d = CAPTURE;
            CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = data_out_i;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            re_q        <= re_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
    assign bus.req_ready  = state_q == IDLE;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_data   = rsp_data_q;
    assign chip_select_o  = cs_q;
    assign write_enable_o = we_q;
    assign read_enable_o  = re_q;
    assign addr_o         = addr_q;
    assign data_in_o      = din_q;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of sram_controller against a behavioural 8-word SRAM.
module tb_sram_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs, we, re;
    logic [7:0] sram_addr, sram_din, sram_dout;
    logic [7:0] mem [0:7];
    int         vectors = 0;
    int         miscompares = 0;
    int         both_hits = 0;
    int         cs_hits = 0;
    int         c0;
    sram_controller_if #(.ADR(8), .DAT(8)) bus ();
    sram_controller #(.ADR(8), .DAT(8), .DPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .chip_select_o(cs), .write_enable_o(we), .read_enable_o(re),
        .addr_o(sram_addr), .data_in_o(sram_din), .data_out_i(sram_dout)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (cs && we) mem[sram_addr[2:0]] <= sram_din;
        else if (cs && re) sram_dout <= mem[sram_addr[2:0]];
        if (we && re) both_hits++;
        if (cs) cs_hits++;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        chk("wr_ready_before", 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_data = d;
        @(negedge clk);
        chk("wr_strobes", {cs, we, re, sram_addr, sram_din}, {1'b1, 1'b1, 1'b0, a, d});
        chk("wr_busy", {bus.req_ready, bus.rsp_valid}, 2'b00);
        bus.req_write = 1'b0; bus.req_addr = ~a; bus.req_data = ~d;
        @(negedge clk);
        chk("wr_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {1'b1, 1'b0, 8'h00});
        chk("wr_after", {bus.req_ready, cs, sram_addr, sram_din}, {1'b1, 1'b0, a, d});
    endtask
    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        chk("rd_ready_before", 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a;
        @(negedge clk);
        chk("rd_strobes", {cs, we, re, sram_addr, bus.req_ready}, {1'b1, 1'b0, 1'b1, a, 1'b0});
        bus.req_write = 1'b1; bus.req_addr = ~a; bus.req_data = 8'h5A;
        @(negedge clk);
        chk("rd_wait", {cs, bus.req_ready, bus.rsp_valid, sram_addr}, {1'b0, 1'b0, 1'b0, a});
        @(negedge clk);
        chk("rd_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.req_ready}, {1'b1, 1'b0, exp, 1'b1});
    endtask
    task automatic er(input logic w, input logic [7:0] a);
        chk("er_ready_before", 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_data = 8'hC3;
        @(negedge clk);
        chk("er_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, {1'b1, 1'b1, 8'h00});
        chk("er_no_strobe", {cs, we, re, bus.req_ready}, 4'b0001);
    endtask
    task automatic idle();
        bus.req_valid = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        sram_dout = 8'h00;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 8'h00; bus.req_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {cs, we, re, sram_addr, sram_din, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 64'h0);
        rst_n = 1'b1;
        chk("reset_ready", 64'(bus.req_ready), 64'(1));
        wr(8'd3, 8'hA5);
        rd(8'd3, 8'hA5);
        idle();
        for (int i = 0; i < 8; i++) wr(8'(i), 8'(i * 17));
        for (int i = 0; i < 8; i++) rd(8'(i), 8'(i * 17));
        idle();
        chk("we_re_exclusive", 64'(both_hits), 64'(0));
        c0 = cs_hits;
        er(1'b1, 8'd8);
        er(1'b0, 8'd255);
        chk("er_cs_never", 64'(cs_hits - c0), 64'(0));
        rd(8'd0, 8'h00);
        rd(8'd7, 8'h77);
        idle();
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'd2;
        @(negedge clk);
        chk("mid_read_strobes", {cs, re}, 2'b11);
        #1 rst_n = 1'b0;
        bus.req_valid = 1'b0;
        #1 chk("mid_read_reset", {cs, we, re, sram_addr, sram_din, bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_read_ready", 64'(bus.req_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_read_no_rsp", {bus.rsp_valid, bus.req_ready}, 2'b01);
        end
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'd5; bus.req_data = 8'hEE;
        @(negedge clk);
        chk("mid_write_strobes", {cs, we, sram_din}, {1'b1, 1'b1, 8'hEE});
        #1 rst_n = 1'b0;
        bus.req_valid = 1'b0;
        #1 chk("mid_write_reset", {cs, we, bus.rsp_valid}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        rd(8'd5, 8'h55);
        idle();
        chk("rsp_data_hold", {bus.rsp_valid, bus.rsp_data}, {1'b0, 8'h55});
        chk("we_re_exclusive_end", 64'(both_hits), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
